// File: rtl/latch_bank_hold.sv
// Multi-channel data-holding bank: per-channel EMPTY/TRACK/HOLD FSM with level or edge-capture load,
// hold-age tracking with a registered STALE flag. Optional even-parity output under LATCH_BANK_PARITY_EN.
module latch_bank_hold #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int MAX_AGE  = 15
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      MODE,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       GATE,
  input  logic [CHANNELS-1:0]       CLEAR,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       VALID,
  output logic [CHANNELS-1:0]       STALE,
`ifdef LATCH_BANK_PARITY_EN
  output logic [CHANNELS-1:0]       PAR,
`endif
  output logic [2*CHANNELS-1:0]     dbg_state
);

  localparam int AW = $clog2(MAX_AGE + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_TRACK = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                state_q [CHANNELS];
  state_t                state_n [CHANNELS];
  logic [AW-1:0]         age_q   [CHANNELS];
  logic [AW-1:0]         age_n   [CHANNELS];
  logic [WIDTH-1:0]      q_n     [CHANNELS];
  logic [CHANNELS-1:0]   gate_r;
  logic [CHANNELS-1:0]   load;

  // Per-channel next state; priority is CLEAR > load > hold.
  always_comb begin
    load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      state_n[i] = state_q[i];
      age_n[i]   = age_q[i];
      q_n[i]     = Q[i*WIDTH +: WIDTH];
      load[i]    = MODE ? (GATE[i] & ~gate_r[i]) : GATE[i];
      if (CLEAR[i]) begin
        state_n[i] = S_EMPTY;
        age_n[i]   = '0;
        q_n[i]     = '0;
      end else if (load[i]) begin
        state_n[i] = MODE ? S_HOLD : S_TRACK;
        age_n[i]   = '0;
        q_n[i]     = D[i*WIDTH +: WIDTH];
      end else begin
        case (state_q[i])
          S_TRACK, S_HOLD: begin
            state_n[i] = S_HOLD;
            if (age_q[i] != AW'(MAX_AGE)) age_n[i] = age_q[i] + 1'b1;
          end
          default: state_n[i] = S_EMPTY;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      Q      <= '0;
      VALID  <= '0;
      STALE  <= '0;
      gate_r <= '0;
`ifdef LATCH_BANK_PARITY_EN
      PAR    <= '0;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= S_EMPTY;
        age_q[i]   <= '0;
      end
    end else begin
      // gate_r follows GATE unconditionally so an edge coincident with CLEAR is consumed.
      gate_r <= GATE;
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]             <= state_n[i];
        age_q[i]               <= age_n[i];
        Q[i*WIDTH +: WIDTH]    <= q_n[i];
        VALID[i]               <= (state_n[i] != S_EMPTY);
        STALE[i]               <= (state_n[i] != S_EMPTY) && (age_n[i] == AW'(MAX_AGE));
`ifdef LATCH_BANK_PARITY_EN
        PAR[i]                 <= ^q_n[i];
`endif
      end
    end
  end

  always_comb begin
    dbg_state = '0;
    for (int i = 0; i < CHANNELS; i++) dbg_state[2*i +: 2] = state_q[i];
  end

endmodule

// File: tb/tb_latch_bank_hold.sv
// Bench for latch_bank_hold: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a per-channel behavioural model.
module tb_latch_bank_hold;

  localparam int W   = 8;
  localparam int CH  = 4;
  localparam int MAX = 15;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic            MODE = 1'b0;
  logic [CH*W-1:0] D = '0;
  logic [CH-1:0]   GATE = '0;
  logic [CH-1:0]   CLEAR = '0;
  logic [CH*W-1:0] Q;
  logic [CH-1:0]   VALID;
  logic [CH-1:0]   STALE;
`ifdef LATCH_BANK_PARITY_EN
  logic [CH-1:0]   PAR;
`endif
  logic [2*CH-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  latch_bank_hold #(.WIDTH(W), .CHANNELS(CH), .MAX_AGE(MAX)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(MODE), .D(D), .GATE(GATE), .CLEAR(CLEAR),
    .Q(Q), .VALID(VALID), .STALE(STALE),
`ifdef LATCH_BANK_PARITY_EN
    .PAR(PAR),
`endif
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: what each channel must hold, straight from the load/clear/age rules.
  logic [W-1:0] m_q   [CH];
  bit           m_val [CH];
  int           m_age [CH];
  bit           m_gd  [CH];

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < CH; i++) begin
        m_q[i] = '0; m_val[i] = 0; m_age[i] = 0; m_gd[i] = 0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        bit ld;
        ld = MODE ? (GATE[i] && !m_gd[i]) : GATE[i];
        if (CLEAR[i]) begin
          m_q[i] = '0; m_val[i] = 0; m_age[i] = 0;
        end else if (ld) begin
          m_q[i] = D[i*W +: W]; m_val[i] = 1; m_age[i] = 0;
        end else if (m_val[i]) begin
          m_age[i] = (m_age[i] < MAX) ? m_age[i] + 1 : MAX;
        end
        m_gd[i] = GATE[i];
      end
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge CLK) begin
    logic [CH*W-1:0] e_q;
    logic [CH-1:0]   e_v, e_s, e_p;
    for (int i = 0; i < CH; i++) begin
      e_q[i*W +: W] = m_q[i];
      e_v[i] = m_val[i];
      e_s[i] = m_val[i] && (m_age[i] == MAX);
      e_p[i] = ^m_q[i];
    end
    checks++;
    if (Q !== e_q) begin errors++; $display("FAIL model_q t=%0t got %h exp %h", $time, Q, e_q); end
    checks++;
    if (VALID !== e_v) begin errors++; $display("FAIL model_valid t=%0t got %b exp %b", $time, VALID, e_v); end
    checks++;
    if (STALE !== e_s) begin errors++; $display("FAIL model_stale t=%0t got %b exp %b", $time, STALE, e_s); end
`ifdef LATCH_BANK_PARITY_EN
    checks++;
    if (PAR !== e_p) begin errors++; $display("FAIL model_par t=%0t got %b exp %b", $time, PAR, e_p); end
`endif
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic set_d(input int ch, input logic [W-1:0] v);
    D[ch*W +: W] = v;
  endtask

  initial begin
    // 1 Reset with active inputs, then release mid-cycle
    D = '1; GATE = '1; MODE = 1'b0; RESET = 1'b1;
    tick(); tick();
    check("reset_q", Q, 32'h0);
    check("reset_valid", {28'h0, VALID}, 32'h0);
    check("reset_stale", {28'h0, STALE}, 32'h0);
    RESET = 1'b0;
    #2;
    check("release_q_held", Q, 32'h0);
    tick();
    check("release_first_load", Q, 32'hFFFF_FFFF);

    // 2 Transparent tracking on channel 0
    GATE = 4'b0001; MODE = 1'b0;
    set_d(0, 8'h11); tick(); check("track_11", {24'h0, Q[7:0]}, 32'h11);
    set_d(0, 8'h22); tick(); check("track_22", {24'h0, Q[7:0]}, 32'h22);
    set_d(0, 8'h33); tick(); check("track_33", {24'h0, Q[7:0]}, 32'h33);
    GATE = 4'b0000; set_d(0, 8'h44); tick();
    check("track_hold", {24'h0, Q[7:0]}, 32'h33);
    check("track_valid", {31'h0, VALID[0]}, 32'h1);

    // 3 Edge capture on channel 1
    MODE = 1'b1; GATE = 4'b0010; set_d(1, 8'hA5); tick();
    set_d(1, 8'h5A);
    for (int k = 0; k < 4; k++) tick();
    check("capture_once", {24'h0, Q[15:8]}, 32'hA5);
    GATE = 4'b0000; tick();
    GATE = 4'b0010; tick();
    check("capture_reedge", {24'h0, Q[15:8]}, 32'h5A);

    // 4 Aging on channel 2
    GATE = 4'b0100; set_d(2, 8'h3C); tick();
    check("age_load", {24'h0, Q[23:16]}, 32'h3C);
    GATE = 4'b0000;
    for (int k = 1; k <= 14; k++) begin
      tick();
      check($sformatf("age_not_stale_%0d", k), {31'h0, STALE[2]}, 32'h0);
    end
    tick(); check("age_stale_15", {31'h0, STALE[2]}, 32'h1);
    tick(); tick(); check("age_stale_sat", {31'h0, STALE[2]}, 32'h1);
    GATE = 4'b0100; set_d(2, 8'h77); tick();
    check("age_reload_clears", {31'h0, STALE[2]}, 32'h0);
    GATE = 4'b0000; tick();

    // 5 Clear wins over a coincident rising gate; the edge is consumed
    CLEAR = 4'b1000; GATE = 4'b1000; set_d(3, 8'hC3); MODE = 1'b1; tick();
    check("clear_q3", {24'h0, Q[31:24]}, 32'h0);
    check("clear_valid3", {31'h0, VALID[3]}, 32'h0);
    CLEAR = 4'b0000; tick();
    check("clear_no_deferred_q3", {24'h0, Q[31:24]}, 32'h0);
    check("clear_no_deferred_v3", {31'h0, VALID[3]}, 32'h0);
    GATE = 4'b0000; tick();

`ifdef LATCH_BANK_PARITY_EN
    // 6 Parity tracks Q on the same edge
    MODE = 1'b0; GATE = 4'b0001;
    set_d(0, 8'h07); tick(); check("par_07", {31'h0, PAR[0]}, 32'h1);
    set_d(0, 8'h03); tick(); check("par_03", {31'h0, PAR[0]}, 32'h0);
    CLEAR = 4'b0001; tick(); check("par_clear", {31'h0, PAR[0]}, 32'h0);
    CLEAR = 4'b0000; GATE = 4'b0000; tick();
`endif

    // Randomized traffic with varying gate density; a mid-cycle reset pulse partway through
    for (int blk = 0; blk < 8; blk++) begin
      int dens;
      dens = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 50 : 92);
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 39) == 0) MODE = ~MODE;
        for (int i = 0; i < CH; i++) begin
          GATE[i]  = ($urandom_range(0, 99) < dens);
          CLEAR[i] = ($urandom_range(0, 59) == 0);
          D[i*W +: W] = W'($urandom);
        end
        if (blk == 5 && c == 200) begin
          #2 RESET = 1'b1;
          #3 RESET = 1'b0;
        end
        tick();
      end
    end

    GATE = '0; CLEAR = '0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
